data_peak_accumulate: RTL and testbench
=======================================

# data_peak_accumulate

Triggered capture-and-average block between the ADC sample register and the serial transmit path. Each FastTrigger captures a fixed window of 32-bit ADC words (four 8-bit samples per word) and sums it sample-by-sample into an accumulator bank. After NUM_ACC windows it averages the sums, finds the peak sample, and streams the averaged bytes plus a peak/index trailer to the transmitter through a read-strobe handshake.

## Interface
Parameters:
- DEPTH, 16: ADC words captured per trigger; 4*DEPTH must be ≤ 256.
- NUM_ACC, 4: triggers accumulated per result; power of two, 1..256.

Ports:
- Clock  in  1: single clock; all logic on the rising edge. One clock; reset is synchronous and active-high.
- Reset  in  1: synchronous, active-high.
- DataIn  in  32: ADC word, fields [31:24] DQD, [23:16] DQ, [15:8] DID, [7:0] DI, unsigned.
- FastTrigger  in  1: capture start, level sampled each cycle.
- TxEnable  in  1: read strobe from the transmitter.
- DataReady  out  1: result available for readout.
- DataValid  out  1: DataOut valid, one-cycle pulse.
- DataOut  out  8: output byte.

## Operation
- Sample order: word w, lane k (k=0 is [7:0] … k=3 is [31:24]) is sample s = 4w+k.
- Accumulators: 4*DEPTH registers, each 8+log2(NUM_ACC) bits wide. Pass counter: 0..NUM_ACC-1.
- States:
  - ARMED: waits for FastTrigger=1, then goes to CAPTURE.
  - CAPTURE: DEPTH cycles. In cycle i (i=0..DEPTH-1, starting the cycle after the trigger), word i is taken from DataIn. On pass 0 each accumulator is loaded with the sample; on later passes the sample is added to it. At the end, the pass counter increments. If passes < NUM_ACC, go to ARMED; otherwise go to SCAN.
  - SCAN: 4*DEPTH cycles. Averages each sample as avg[s] = acc[s] >> log2(NUM_ACC) (truncation). Tracks the maximum average and its index; on a tie the lowest index wins. Then go to READOUT.
  - READOUT: DataReady=1. Bytes are sent in order avg[0] … avg[4*DEPTH-1], then peak value, then peak index. Total 4*DEPTH+2 bytes. After the last byte, DataReady drops, the pass counter clears, and the block returns to ARMED.
- FastTrigger is ignored in CAPTURE, SCAN and READOUT.
- TxEnable is ignored outside READOUT, and ignored in any cycle where DataValid=1.
- Reset in any state aborts the operation:
  - state goes to ARMED; pass counter and read pointer clear;
  - accumulator contents need not be cleared, because pass 0 overwrites them.

## Timing
- Reset values: DataReady=0, DataValid=0, DataOut=0x00.
- Trigger sampled in cycle T: words are captured in cycles T+1 … T+DEPTH.
- Final pass: DataReady rises in cycle T+DEPTH+4*DEPTH+1, and is registered.
- Read handshake: TxEnable=1 in cycle R (READOUT, DataValid=0) gives DataOut=next byte and DataValid=1 in cycle R+1 only. DataOut holds its value until the next read.
- Maximum read rate: one byte every 2 cycles, with TxEnable held high.
- DataReady falls in the same cycle the final DataValid pulse is asserted.
- A trigger arriving in the first ARMED cycle after a capture is accepted: back-to-back passes are allowed.
- Arithmetic cannot overflow: 255*NUM_ACC fits the accumulator width.

## Test plan
- DEPTH=16, NUM_ACC=4. DataIn constant 0x40302010 for 4 triggers, reading with TxEnable held high:
  - 66 DataValid pulses, 2 cycles apart;
  - bytes 0x10,0x20,0x30,0x40 repeated 16 times, then peak 0x40, then index 0x03;
  - DataReady falls with the 66th pulse.
- Sample 0 set to 0xFF, 0xFF, 0x00, 0x01 across the 4 passes, all other samples 0: first byte 0x7F, peak 0x7F, index 0x00.
- Ramp, word w = {4w+3, 4w+2, 4w+1, 4w}, for 4 passes: bytes 0x00..0x3F in order, peak 0x3F, index 0x3F.
- FastTrigger pulsed again 3 cycles into CAPTURE and during READOUT: both are ignored; byte stream identical to the single-trigger case.
- Only 3 of 4 triggers given: DataReady stays 0; TxEnable produces no DataValid.
- Reset asserted mid-READOUT: next cycle DataReady=0, DataValid=0, DataOut=0x00. A fresh 4-trigger sequence then yields a complete, correct 66-byte stream.

Source files
------------

// File: rtl/data_peak_if.sv
// Transmit-side bundle for data_peak_accumulate: ADC word in, trigger in,
// read strobe in, and the byte-wide readout returned to the transmitter.
interface data_peak_if;
    // Read handshake: the transmitter raises TxEnable while DataReady=1; each
    // accepted strobe returns one byte with a single-cycle DataValid pulse the
    // next cycle, and strobes seen while DataValid=1 are not accepted.
    logic [31:0] DataIn;
    logic        FastTrigger;
    logic        TxEnable;
    logic        DataReady;
    logic        DataValid;
    logic [7:0]  DataOut;

    modport master (
        output DataIn, FastTrigger, TxEnable,
        input  DataReady, DataValid, DataOut
    );

    modport slave (
        input  DataIn, FastTrigger, TxEnable,
        output DataReady, DataValid, DataOut
    );
endinterface

// File: rtl/data_peak_accumulate.sv
// Triggered window capture, NUM_ACC-pass sample accumulation, averaging with
// peak search, and byte-serial readout of the averages plus a peak trailer.
module data_peak_accumulate #(
    parameter int DEPTH   = 16,
    parameter int NUM_ACC = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    data_peak_if.slave  bus,
    output logic [1:0]  dbg_state
);
    localparam int N     = 4 * DEPTH;
    localparam int SH    = $clog2(NUM_ACC);
    localparam int ACC_W = 8 + SH;
    localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = CW + 2;
    localparam int PW    = $clog2(N + 2);
    localparam int PCW   = (SH > 0) ? SH : 1;

    localparam logic [1:0] ARMED   = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] SCAN    = 2'd2;
    localparam logic [1:0] READOUT = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cap_cnt;
    logic [IW-1:0]    scan_idx;
    logic [PCW-1:0]   pass_cnt;
    logic [PW-1:0]    rd_ptr;
    logic [7:0]       peak_val;
    logic [7:0]       peak_idx;
    logic [ACC_W-1:0] acc [N];
    logic [ACC_W-1:0] scan_shift;
    logic [ACC_W-1:0] rd_shift;
    logic [7:0]       scan_avg;
    logic [7:0]       next_byte;
    logic             rd_fire;

    assign dbg_state = state;
    assign rd_fire   = (state == READOUT) && bus.TxEnable && !bus.DataValid;

    always_comb begin
        scan_shift = acc[scan_idx] >> SH;
        scan_avg   = scan_shift[7:0];
        rd_shift   = acc[rd_ptr[IW-1:0]] >> SH;
        next_byte  = rd_shift[7:0];
        if (rd_ptr == PW'(N)) begin
            next_byte = peak_val;
        end else if (rd_ptr == PW'(N + 1)) begin
            next_byte = peak_idx;
        end
    end

    // Accumulators carry no reset: pass 0 always overwrites every entry.
    always_ff @(posedge Clock) begin
        if (state == CAPTURE) begin
            for (int k = 0; k < 4; k++) begin
                if (pass_cnt == '0) begin
                    acc[{cap_cnt, 2'(k)}] <= ACC_W'(bus.DataIn[8*k +: 8]);
                end else begin
                    acc[{cap_cnt, 2'(k)}] <= acc[{cap_cnt, 2'(k)}] + ACC_W'(bus.DataIn[8*k +: 8]);
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= ARMED;
            cap_cnt       <= '0;
            scan_idx      <= '0;
            pass_cnt      <= '0;
            rd_ptr        <= '0;
            peak_val      <= '0;
            peak_idx      <= '0;
            bus.DataReady <= 1'b0;
            bus.DataValid <= 1'b0;
            bus.DataOut   <= 8'h00;
        end else begin
            bus.DataValid <= 1'b0;
            case (state)
                ARMED: begin
                    cap_cnt <= '0;
                    if (bus.FastTrigger) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    cap_cnt <= cap_cnt + 1'b1;
                    if (cap_cnt == CW'(DEPTH - 1)) begin
                        pass_cnt <= pass_cnt + 1'b1;
                        scan_idx <= '0;
                        state    <= (pass_cnt == PCW'(NUM_ACC - 1)) ? SCAN : ARMED;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on equal averages.
                    if (scan_idx == '0 || scan_avg > peak_val) begin
                        peak_val <= scan_avg;
                        peak_idx <= 8'(scan_idx);
                    end
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == IW'(N - 1)) begin
                        state         <= READOUT;
                        rd_ptr        <= '0;
                        bus.DataReady <= 1'b1;
                    end
                end
                READOUT: begin
                    if (rd_fire) begin
                        bus.DataValid <= 1'b1;
                        bus.DataOut   <= next_byte;
                        rd_ptr        <= rd_ptr + 1'b1;
                        if (rd_ptr == PW'(N + 1)) begin
                            bus.DataReady <= 1'b0;
                            pass_cnt      <= '0;
                            state         <= ARMED;
                        end
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end
endmodule

// File: tb/tb_data_peak_accumulate.sv
// Directed bench for data_peak_accumulate: model-built expected byte streams
// are queued as passes are driven and popped as DataValid pulses arrive.
module tb_data_peak_accumulate;
    localparam int DEPTH   = 16;
    localparam int NUM_ACC = 4;
    localparam int N       = 4 * DEPTH;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] dbg_state;

    data_peak_if bus();

    data_peak_accumulate #(.DEPTH(DEPTH), .NUM_ACC(NUM_ACC)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 Clock = ~Clock;

    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    int         stream_pulses = 0;
    int         last_pulse = 0;
    int         model_acc [N];
    logic [7:0] exp_q [$];

    always @(posedge Clock) cycle++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every DataValid pulse consumes one expected byte.
    always @(negedge Clock) begin
        if (bus.DataValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, bus.DataValid}, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("data_byte", {24'd0, bus.DataOut}, {24'd0, e});
                check("ready_with_pulse", {31'd0, bus.DataReady}, {31'd0, exp_q.size() != 0});
                if (stream_pulses > 0) check("pulse_gap", cycle - last_pulse, 2);
                stream_pulses++;
                last_pulse = cycle;
            end
        end
    end

    function automatic logic [31:0] make_word(input int mode, input int pass, input int w);
        logic [7:0] s0;
        case (pass)
            0: s0 = 8'hFF;
            1: s0 = 8'hFF;
            2: s0 = 8'h00;
            default: s0 = 8'h01;
        endcase
        case (mode)
            0: return 32'h40302010;
            1: return (w == 0) ? {24'd0, s0} : 32'd0;
            default: return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        endcase
    endfunction

    task automatic clear_model();
        for (int s = 0; s < N; s++) model_acc[s] = 0;
    endtask

    task automatic run_pass(input int mode, input int pass, input bit retrigger);
        logic [31:0] word;
        @(negedge Clock);
        bus.FastTrigger = 1'b1;
        @(negedge Clock);
        for (int w = 0; w < DEPTH; w++) begin
            word = make_word(mode, pass, w);
            bus.DataIn = word;
            for (int k = 0; k < 4; k++) model_acc[4*w+k] += int'(word[8*k +: 8]);
            bus.FastTrigger = (retrigger && w == 3);
            if (w < DEPTH - 1) @(negedge Clock);
        end
        bus.FastTrigger = 1'b0;
    endtask

    // Called right after the final pass: ready must rise exactly 4*DEPTH+1 cycles on.
    task automatic check_ready_rise();
        repeat (N) @(negedge Clock);
        check("ready_before_rise", {31'd0, bus.DataReady}, 32'd0);
        @(negedge Clock);
        check("ready_rise", {31'd0, bus.DataReady}, 32'd1);
    endtask

    task automatic push_expected();
        int pv;
        int pi;
        int a;
        pv = -1;
        pi = 0;
        for (int s = 0; s < N; s++) begin
            a = model_acc[s] / NUM_ACC;
            exp_q.push_back(8'(a));
            if (a > pv) begin
                pv = a;
                pi = s;
            end
        end
        exp_q.push_back(8'(pv));
        exp_q.push_back(8'(pi));
    endtask

    task automatic run_sequence(input int mode, input bit retrigger);
        clear_model();
        for (int p = 0; p < NUM_ACC; p++) run_pass(mode, p, retrigger && p == 0);
        check_ready_rise();
        push_expected();
    endtask

    task automatic read_all(input int trig_at);
        stream_pulses = 0;
        bus.TxEnable = 1'b1;
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            @(negedge Clock);
            bus.FastTrigger = (c == trig_at);
        end
        bus.FastTrigger = 1'b0;
        check("stream_complete", exp_q.size(), 0);
        @(negedge Clock);
        bus.TxEnable = 1'b0;
        check("pulse_count", stream_pulses, N + 2);
        check("ready_after_stream", {31'd0, bus.DataReady}, 32'd0);
        repeat (3) @(negedge Clock);
        check("state_armed", {30'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        bus.DataIn = '0;
        bus.FastTrigger = 1'b0;
        bus.TxEnable = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_ready", {31'd0, bus.DataReady}, 32'd0);
        check("reset_valid", {31'd0, bus.DataValid}, 32'd0);
        check("reset_dataout", {24'd0, bus.DataOut}, 32'h00);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        Reset = 1'b0;

        // Constant word: repeating 10/20/30/40, peak 0x40 at index 3.
        run_sequence(0, 1'b0);
        read_all(-1);
        check("dataout_hold", {24'd0, bus.DataOut}, 32'h03);

        // Sample 0 sums to 0x1FF, averaging to 0x7F.
        run_sequence(1, 1'b0);
        read_all(-1);

        // Ramp: averages equal the sample index.
        run_sequence(2, 1'b0);
        read_all(-1);
        check("ramp_last_index", {24'd0, bus.DataOut}, 32'h3F);

        // Retriggers in CAPTURE and READOUT must not disturb the stream.
        run_sequence(0, 1'b1);
        read_all(9);

        // Three passes only: no result, strobes ignored.
        clear_model();
        for (int p = 0; p < NUM_ACC - 1; p++) run_pass(0, p, 1'b0);
        bus.TxEnable = 1'b1;
        repeat (100) @(negedge Clock);
        bus.TxEnable = 1'b0;
        check("partial_no_ready", {31'd0, bus.DataReady}, 32'd0);
        check("partial_armed", {30'd0, dbg_state}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;

        // Abort mid-readout, then a fresh full sequence.
        run_sequence(0, 1'b0);
        stream_pulses = 0;
        bus.TxEnable = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > N - 8; c++) @(negedge Clock);
        bus.TxEnable = 1'b0;
        repeat (2) @(negedge Clock);
        check("midread_ready_high", {31'd0, bus.DataReady}, 32'd1);
        Reset = 1'b1;
        exp_q.delete();
        @(negedge Clock);
        Reset = 1'b0;
        check("abort_ready", {31'd0, bus.DataReady}, 32'd0);
        check("abort_valid", {31'd0, bus.DataValid}, 32'd0);
        check("abort_dataout", {24'd0, bus.DataOut}, 32'h00);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        run_sequence(2, 1'b0);
        read_all(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
